fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks IDLE -> FETCH -> EXEC, follows compare-branch results,
// keeps S/Z/V flags for the branch checker and counts retired instructions.
module fetch_sequencer #(
  parameter logic [11:0] RESET_PC   = 12'h000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_address,
  output logic        instr_valid,
  input  logic [11:0] cmpb_address,
  input  logic        is_cmpb_satisfied,
  input  logic        alu_flags_we,
  input  logic        alu_s,
  input  logic        alu_z,
  input  logic        alu_v,
  output logic        sign_flag,
  output logic        zero_flag,
  output logic        overflow_flag,
  output logic        branch_taken,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] instr_pc_q, instr_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] count_q, count_d;
  logic        branch_q, branch_d;
  logic        sign_q, zero_q, ovf_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    branch_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          state_d    = StExec;
        end
      end
      StExec: begin
        // A halt does not retire: pc and the counter stay where they are.
        if (!stall) begin
          if (instr_q == HALT_INSTR) begin
            state_d = StHalt;
          end else begin
            count_d = count_q + 16'd1;
            state_d = StFetch;
            if (is_cmpb_satisfied) begin
              pc_d     = cmpb_address;
              branch_d = 1'b1;
            end else begin
              pc_d = pc_q + 12'd1;
            end
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_pc_q <= 12'h000;
      instr_q    <= 16'h0000;
      count_q    <= 16'h0000;
      branch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      branch_q   <= branch_d;
    end
  end

  // Flags update in every state; the checker sees the old values during the write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (alu_flags_we) begin
      sign_q <= alu_s;
      zero_q <= alu_z;
      ovf_q  <= alu_v;
    end
  end

  assign imem_req      = (state_q == StFetch);
  assign imem_addr     = {4'b0000, pc_q};
  assign instr         = instr_q;
  assign instr_address = {4'b0000, instr_pc_q};
  assign instr_valid   = (state_q == StExec);
  assign sign_flag     = sign_q;
  assign zero_flag     = zero_q;
  assign overflow_flag = ovf_q;
  assign branch_taken  = branch_q;
  assign halted        = (state_q == StHalt);
  assign instr_count   = count_q;

endmodule
